// File: rtl/data_sync_hs.sv
// Receive side of a 4-phase req/ack CDC handshake: synchronises req, captures the
// quasi-static data bus, hands it to a valid/ready consumer and returns ack.
module data_sync_hs #(
    parameter int D_WIDTH     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               req_i,
    input  logic [D_WIDTH-1:0] data_i,
    output logic               ack_o,
    output logic [D_WIDTH-1:0] data_o,
    output logic               valid_o,
    input  logic               ready_i,
    output logic               busy_o,
    output logic               err_o
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RDY = 2'd1,
        WAIT_REL = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [SYNC_STAGES-1:0] req_sync_q;
    logic                 req_s;
    logic                 ack_d, valid_d, err_d;
    logic [D_WIDTH-1:0]   data_d;

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_stages
            $error("data_sync_hs: SYNC_STAGES must be in 2..4");
        end
    endgenerate

    // Only req crosses through flops; data_i is trusted stable whenever req_s is high.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) req_sync_q <= '0;
        else       req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], req_i};
    end

    assign req_s = req_sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            ack_o   <= 1'b0;
            valid_o <= 1'b0;
            data_o  <= '0;
            err_o   <= 1'b0;
            busy_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_o   <= ack_d;
            valid_o <= valid_d;
            data_o  <= data_d;
            err_o   <= err_d;
            busy_o  <= (state_d != IDLE);
        end
    end

    always_comb begin
        state_d = state_q;
        ack_d   = ack_o;
        valid_d = valid_o;
        data_d  = data_o;
        err_d   = err_o;
        case (state_q)
            IDLE: begin
                if (req_s) begin
                    data_d  = data_i;
                    valid_d = 1'b1;
                    state_d = WAIT_RDY;
                end
            end
            WAIT_RDY: begin
                // Early release is flagged but the word is still delivered and acked
                // so the sender never deadlocks.
                if (!req_s) err_d = 1'b1;
                if (valid_o && ready_i) begin
                    valid_d = 1'b0;
                    ack_d   = 1'b1;
                    state_d = WAIT_REL;
                end
            end
            WAIT_REL: begin
                if (!req_s) begin
                    ack_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ack_d   = 1'b0;
                valid_d = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_data_sync_hs.sv
// Bench for data_sync_hs: directed handshake scenarios plus a randomized sender/consumer
// run scored against a queue of words the sender has offered.
module tb_data_sync_hs;

    localparam int S_A = 2;
    localparam int S_B = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        req = 1'b0, ready = 1'b0;
    logic [7:0]  data = '0;
    logic        ack, valid, busy, err;
    logic [7:0]  dout;

    logic        req4 = 1'b0, ready4 = 1'b0;
    logic [31:0] data4 = '0;
    logic        ack4, valid4, busy4, err4;
    logic [31:0] dout4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    data_sync_hs #(.D_WIDTH(8), .SYNC_STAGES(S_A)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data), .ack_o(ack),
        .data_o(dout), .valid_o(valid), .ready_i(ready), .busy_o(busy), .err_o(err)
    );

    data_sync_hs #(.D_WIDTH(32), .SYNC_STAGES(S_B)) dut4 (
        .clk_i(clk), .rst_i(rst), .req_i(req4), .data_i(data4), .ack_o(ack4),
        .data_o(dout4), .valid_o(valid4), .ready_i(ready4), .busy_o(busy4), .err_o(err4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Reference model for the random run: words offered by the sender, in order.
    logic [7:0] exp_q[$];
    bit         sender_done;
    int         delivered;

    task automatic sender(input int n_words);
        logic [7:0] w;
        int         to;
        for (int i = 0; i < n_words; i++) begin
            w = (i < 3) ? 8'(i + 1) : 8'($urandom);
            data = w;
            exp_q.push_back(w);
            req = 1'b1;
            to = 0;
            while (!ack && to < 200) begin tick(); to++; end
            if (to >= 200) chk("snd_ack_rise_timeout", 32'(ack), 32'd1);
            req  = 1'b0;
            data = 8'($urandom);
            to = 0;
            while (ack && to < 200) begin tick(); to++; end
            if (to >= 200) chk("snd_ack_fall_timeout", 32'(ack), 32'd0);
            repeat ($urandom_range(0, 3)) tick();
        end
        sender_done = 1'b1;
    endtask

    task automatic consumer();
        int guard = 0;
        while ((!sender_done || exp_q.size() != 0) && guard < 20000) begin
            ready = 1'b0;
            if (valid && ($urandom_range(0, 2) != 0)) begin
                if (exp_q.size() == 0) begin
                    chk("dup_word", 32'(valid), 32'd0);
                end else begin
                    chk("rand_word", 32'(dout), 32'(exp_q[0]));
                    void'(exp_q.pop_front());
                    delivered++;
                end
                ready = 1'b1;
            end
            tick();
            guard++;
        end
        ready = 1'b0;
        if (guard >= 20000) chk("consumer_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int to;

        // Reset values on both instances while reset is held
        tick();
        chk("rst_ack",   32'(ack),   32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy",  32'(busy),  32'd0);
        chk("rst_err",   32'(err),   32'd0);
        chk("rst_data",  32'(dout),  32'd0);
        chk("rst_valid4", 32'(valid4), 32'd0);
        chk("rst_data4",  dout4,       32'd0);
        rst = 1'b0;
        tick();

        // Basic transfer with ready already high: valid on the S+1-th edge counting
        // the edge that first samples req high.
        data = 8'hA5; ready = 1'b1; req = 1'b1;
        repeat (S_A) tick();
        chk("basic_valid_early", 32'(valid), 32'd0);
        tick();
        chk("basic_valid", 32'(valid), 32'd1);
        chk("basic_data",  32'(dout),  32'hA5);
        chk("basic_busy",  32'(busy),  32'd1);
        tick();
        chk("basic_valid_drop", 32'(valid), 32'd0);
        chk("basic_ack",        32'(ack),   32'd1);
        req = 1'b0;
        repeat (S_A) tick();
        chk("basic_ack_hold", 32'(ack), 32'd1);
        tick();
        chk("basic_ack_fall", 32'(ack),  32'd0);
        chk("basic_idle",     32'(busy), 32'd0);
        chk("basic_persist",  32'(dout), 32'hA5);
        ready = 1'b0;
        tick();

        // Backpressure
        data = 8'h3C; req = 1'b1;
        to = 0;
        while (!valid && to < 20) begin tick(); to++; end
        chk("bp_valid_rise", 32'(valid), 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid_hold", 32'(valid), 32'd1);
            chk("bp_data_hold",  32'(dout),  32'h3C);
            chk("bp_ack_low",    32'(ack),   32'd0);
        end
        ready = 1'b1;
        tick();
        chk("bp_valid_fall", 32'(valid), 32'd0);
        chk("bp_ack_rise",   32'(ack),   32'd1);
        ready = 1'b0; req = 1'b0;
        to = 0;
        while (ack && to < 20) begin tick(); to++; end
        chk("bp_ack_fall", 32'(ack), 32'd0);
        tick();

        // Back-to-back words through sender/consumer, first three are 01,02,03
        sender_done = 1'b0;
        delivered   = 0;
        fork
            sender(20);
            consumer();
        join
        chk("rand_count", 32'(delivered), 32'd20);
        chk("rand_err",   32'(err),       32'd0);
        repeat (3) tick();

        // Early release in WAIT_RDY
        data = 8'h5A; req = 1'b1; ready = 1'b0;
        to = 0;
        while (!valid && to < 20) begin tick(); to++; end
        chk("early_valid", 32'(valid), 32'd1);
        req = 1'b0;
        repeat (S_A + 1) tick();
        chk("early_err",   32'(err),   32'd1);
        chk("early_valid_hold", 32'(valid), 32'd1);
        chk("early_data",  32'(dout),  32'h5A);
        ready = 1'b1;
        tick();
        chk("early_ack",   32'(ack),   32'd1);
        ready = 1'b0;
        tick();
        chk("early_ack_fall", 32'(ack),  32'd0);
        chk("early_idle",     32'(busy), 32'd0);
        repeat (5) tick();
        chk("early_err_sticky", 32'(err), 32'd1);
        do_reset();
        chk("early_err_clear", 32'(err), 32'd0);

        // Reset during WAIT_REL, req kept high across it -> exactly one re-capture
        data = 8'hC3; req = 1'b1; ready = 1'b1;
        to = 0;
        while (!ack && to < 20) begin tick(); to++; end
        chk("mid_ack", 32'(ack), 32'd1);
        ready = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_ack",   32'(ack),   32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_busy",  32'(busy),  32'd0);
        chk("mid_rst_data",  32'(dout),  32'd0);
        tick();
        rst = 1'b0;
        repeat (S_A) tick();
        chk("mid_recap_early", 32'(valid), 32'd0);
        tick();
        chk("mid_recap_valid", 32'(valid), 32'd1);
        chk("mid_recap_data",  32'(dout),  32'hC3);
        ready = 1'b1;
        tick();
        ready = 1'b0; req = 1'b0;
        to = 0;
        while (ack && to < 20) begin tick(); to++; end
        chk("mid_ack_fall", 32'(ack), 32'd0);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("mid_no_dup", 32'(valid), 32'd0);
        end

        // Wide instance with four sync stages
        data4 = 32'hDEADBEEF; req4 = 1'b1; ready4 = 1'b0;
        repeat (S_B) tick();
        chk("w_valid_early", 32'(valid4), 32'd0);
        tick();
        chk("w_valid", 32'(valid4), 32'd1);
        chk("w_data",  dout4,       32'hDEADBEEF);
        ready4 = 1'b1;
        tick();
        chk("w_ack", 32'(ack4), 32'd1);
        ready4 = 1'b0; req4 = 1'b0;
        repeat (S_B) tick();
        chk("w_ack_hold", 32'(ack4), 32'd1);
        tick();
        chk("w_ack_fall", 32'(ack4), 32'd0);
        chk("w_err",      32'(err4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
